// File: rtl/mem_port_arbiter_pkg.sv
// ============================================================================
// Module  : mem_port_arbiter_pkg
// Brief   : Shared types and constants for the fetch/data memory port arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_port_arbiter_pkg;

   typedef enum logic {
      SRC_I = 1'b0,
      SRC_D = 1'b1
   } src_e;

   localparam int c_VALID_W = 1;
   localparam int c_SRC_W   = 1;
   localparam int c_TAG_W   = c_VALID_W + c_SRC_W;

   typedef struct packed {
      logic valid;
      src_e src;
   } tag_t;

   localparam int c_LAT_MIN    = 1;
   localparam int c_LAT_MAX    = 4;
   localparam int c_STARVE_MIN = 1;
   localparam int c_STARVE_MAX = 15;

   function automatic bit in_range(input int val, input int lo, input int hi);
      return (val >= lo) && (val <= hi);
   endfunction

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
// ============================================================================
// Module  : mem_port_arbiter_if
// Brief   : Fetch, data and memory command/response bundle for the arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic                  i_req;
   logic [ADDR_W-1:0]     i_addr;
   logic                  i_gnt;
   logic                  i_kill;
   logic                  i_rvalid;
   logic [DATA_W-1:0]     i_rdata;

   logic                  d_req;
   logic                  d_we;
   logic [DATA_W/8-1:0]   d_be;
   logic [ADDR_W-1:0]     d_addr;
   logic [DATA_W-1:0]     d_wdata;
   logic                  d_gnt;
   logic                  d_rvalid;
   logic [DATA_W-1:0]     d_rdata;

   logic                  mem_req;
   logic                  mem_we;
   logic [DATA_W/8-1:0]   mem_be;
   logic [ADDR_W-1:0]     mem_addr;
   logic [DATA_W-1:0]     mem_wdata;
   logic [DATA_W-1:0]     mem_rdata;

   // Arbiter side
   modport slave (
      input  i_req, i_addr, i_kill,
      input  d_req, d_we, d_be, d_addr, d_wdata,
      input  mem_rdata,
      output i_gnt, i_rvalid, i_rdata,
      output d_gnt, d_rvalid, d_rdata,
      output mem_req, mem_we, mem_be, mem_addr, mem_wdata
   );

   // Requester and memory side
   modport master (
      output i_req, i_addr, i_kill,
      output d_req, d_we, d_be, d_addr, d_wdata,
      output mem_rdata,
      input  i_gnt, i_rvalid, i_rdata,
      input  d_gnt, d_rvalid, d_rdata,
      input  mem_req, mem_we, mem_be, mem_addr, mem_wdata
   );
endinterface

`default_nettype wire

// File: rtl/mem_arb_tag_pipe.sv
// ============================================================================
// Module  : mem_arb_tag_pipe
// Brief   : LAT-deep {valid, src} shift register with kill-by-source.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arb_tag_pipe
   import mem_port_arbiter_pkg::*;
#(
   parameter int LAT = 2
) (
   input  wire logic clk,
   input  wire logic reset,
   input  wire logic in_valid,
   input  wire src_e in_src,
   input  wire logic kill,
   input  wire src_e kill_src,
   output tag_t      tail
);

   tag_t r_tags [LAT];

   // The entry loaded this edge is the redirect target, so kill only touches older entries.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < LAT; i++) begin
            r_tags[i].valid <= 1'b0;
            r_tags[i].src   <= SRC_I;
         end
      end else begin
         r_tags[0].valid <= in_valid;
         r_tags[0].src   <= in_src;
         for (int i = 1; i < LAT; i++) begin
            r_tags[i].valid <= r_tags[i-1].valid && !(kill && (r_tags[i-1].src == kill_src));
            r_tags[i].src   <= r_tags[i-1].src;
         end
      end
   end

   assign tail = r_tags[LAT-1];

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module  : mem_port_arbiter
// Brief   : Single-port memory arbiter, data priority with bounded fetch starvation.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int LAT        = 2,
   parameter int STARVE_MAX = 4
) (
   input  wire logic           clk,
   input  wire logic           reset,
   mem_port_arbiter_if.slave   bus,
   output logic [15:0]         conflict_cnt
);

   generate
      if (!in_range(LAT, c_LAT_MIN, c_LAT_MAX) ||
          !in_range(STARVE_MAX, c_STARVE_MIN, c_STARVE_MAX)) begin : g_param_guard
         $error("mem_port_arbiter: LAT or STARVE_MAX out of legal range");
      end
   endgenerate

   localparam int                CNT_W        = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0]  c_STARVE_LIM = CNT_W'(STARVE_MAX);

   logic [CNT_W-1:0]    r_starve_cnt;
   logic [15:0]         r_conflict_cnt;
   logic                w_force_i;
   logic                w_i_gnt;
   logic                w_d_gnt;
   logic [ADDR_W-1:0]   w_mem_addr;
   logic [DATA_W-1:0]   w_mem_wdata;
   tag_t                w_tail;

   // Grants are held low while reset is asserted.
   always_comb begin
      w_force_i = bus.i_req && (r_starve_cnt == c_STARVE_LIM);
      w_d_gnt   = reset && bus.d_req && !w_force_i;
      w_i_gnt   = reset && bus.i_req && !w_d_gnt;
   end

   assign w_mem_addr  = w_d_gnt ? bus.d_addr : bus.i_addr;
   assign w_mem_wdata = bus.d_wdata;

   assign bus.i_gnt     = w_i_gnt;
   assign bus.d_gnt     = w_d_gnt;
   assign bus.mem_req   = w_i_gnt | w_d_gnt;
   assign bus.mem_we    = w_d_gnt & bus.d_we;
   assign bus.mem_be    = w_d_gnt ? bus.d_be : '0;
   assign bus.mem_addr  = w_mem_addr;
   assign bus.mem_wdata = w_mem_wdata;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_starve_cnt   <= '0;
         r_conflict_cnt <= '0;
      end else begin
         if (!bus.i_req || w_i_gnt) begin
            r_starve_cnt <= '0;
         end else if (r_starve_cnt != c_STARVE_LIM) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
         end
         if (bus.i_req && bus.d_req && (r_conflict_cnt != 16'hFFFF)) begin
            r_conflict_cnt <= r_conflict_cnt + 16'd1;
         end
      end
   end

   assign conflict_cnt = r_conflict_cnt;

   mem_arb_tag_pipe #(
      .LAT (LAT)
   ) u_tag_pipe (
      .clk      (clk),
      .reset    (reset),
      .in_valid (bus.mem_req && !bus.mem_we),
      .in_src   (src_e'(w_d_gnt)),
      .kill     (bus.i_kill),
      .kill_src (SRC_I),
      .tail     (w_tail)
   );

   // A fetch response colliding with a redirect is wrong-path and is dropped.
   assign bus.i_rvalid = reset && w_tail.valid && (w_tail.src == SRC_I) && !bus.i_kill;
   assign bus.d_rvalid = reset && w_tail.valid && (w_tail.src == SRC_D);
   assign bus.i_rdata  = bus.mem_rdata;
   assign bus.d_rdata  = bus.mem_rdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module  : tb_mem_port_arbiter
// Brief   : Vector table plus response scoreboard for mem_port_arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

   localparam int LAT        = 2;
   localparam int STARVE_MAX = 4;

   typedef struct packed {
      logic        rst;
      logic        ireq;
      logic [31:0] iaddr;
      logic        ikill;
      logic        dreq;
      logic        dwe;
      logic [3:0]  dbe;
      logic [31:0] daddr;
      logic [31:0] dwdata;
      logic        eig;
      logic        edg;
   } vec_t;

   typedef struct {
      logic        src;
      logic [31:0] data;
      int          due;
      logic        killed;
   } sb_t;

   logic        clk;
   logic        reset;
   logic [15:0] conflict_cnt;
   logic [31:0] mem_pipe [LAT];

   int   errors   = 0;
   int   checks   = 0;
   int   cyc      = 0;
   int   exp_conf = 0;
   sb_t  q [$];
   vec_t tbl [$];

   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   mem_port_arbiter #(
      .ADDR_W     (32),
      .DATA_W     (32),
      .LAT        (LAT),
      .STARVE_MAX (STARVE_MAX)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .bus          (bus.slave),
      .conflict_cnt (conflict_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_val(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
   endfunction

   // Memory model: read data appears exactly LAT cycles after the command.
   always @(posedge clk) begin
      for (int i = LAT - 1; i > 0; i--) mem_pipe[i] <= mem_pipe[i-1];
      mem_pipe[0] <= (bus.mem_req && !bus.mem_we) ? mem_val(bus.mem_addr) : 32'hDEAD_BEEF;
   end
   assign bus.mem_rdata = mem_pipe[LAT-1];

   function automatic vec_t mk(input logic rst, input logic ireq, input logic [31:0] iaddr,
                               input logic ikill, input logic dreq, input logic dwe,
                               input logic [3:0] dbe, input logic [31:0] daddr,
                               input logic [31:0] dwdata, input logic eig, input logic edg);
      vec_t v;
      v.rst = rst; v.ireq = ireq; v.iaddr = iaddr; v.ikill = ikill;
      v.dreq = dreq; v.dwe = dwe; v.dbe = dbe; v.daddr = daddr; v.dwdata = dwdata;
      v.eig = eig; v.edg = edg;
      return v;
   endfunction

   function automatic vec_t idle(input logic kill);
      return mk(1'b1, 1'b0, 32'h0, kill, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0);
   endfunction

   function automatic vec_t fetch(input logic [31:0] a, input logic kill);
      return mk(1'b1, 1'b1, a, kill, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0);
   endfunction

   function automatic vec_t load(input logic [31:0] a);
      return mk(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 4'hF, a, 32'h0, 1'b0, 1'b1);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   task automatic step(input vec_t v);
      sb_t  e;
      logic exp_iv;
      logic exp_dv;
      logic [31:0] exp_data;
      reset       = v.rst;
      bus.i_req   = v.ireq;
      bus.i_addr  = v.iaddr;
      bus.i_kill  = v.ikill;
      bus.d_req   = v.dreq;
      bus.d_we    = v.dwe;
      bus.d_be    = v.dbe;
      bus.d_addr  = v.daddr;
      bus.d_wdata = v.dwdata;
      @(negedge clk);
      if (!v.rst) begin
         q.delete();
         exp_conf = 0;
      end
      chk("conflict_cnt", {16'h0, conflict_cnt}, exp_conf[31:0]);
      chk("i_gnt", {31'h0, bus.i_gnt}, {31'h0, v.eig});
      chk("d_gnt", {31'h0, bus.d_gnt}, {31'h0, v.edg});
      chk("mem_req", {31'h0, bus.mem_req}, {31'h0, v.eig | v.edg});
      if (v.eig || v.edg) begin
         chk("mem_addr", bus.mem_addr, v.edg ? v.daddr : v.iaddr);
         chk("mem_we", {31'h0, bus.mem_we}, {31'h0, v.edg & v.dwe});
         chk("mem_be", {28'h0, bus.mem_be}, v.edg ? {28'h0, v.dbe} : 32'h0);
         if (v.edg && v.dwe) chk("mem_wdata", bus.mem_wdata, v.dwdata);
      end
      if (v.ikill) begin
         foreach (q[i]) if (q[i].src == 1'b0) q[i].killed = 1'b1;
      end
      exp_iv   = 1'b0;
      exp_dv   = 1'b0;
      exp_data = 32'h0;
      if (q.size() > 0 && q[0].due == cyc) begin
         e        = q.pop_front();
         exp_iv   = !e.src && !e.killed;
         exp_dv   = e.src;
         exp_data = e.data;
      end
      chk("i_rvalid", {31'h0, bus.i_rvalid}, {31'h0, exp_iv});
      chk("d_rvalid", {31'h0, bus.d_rvalid}, {31'h0, exp_dv});
      if (exp_iv) chk("i_rdata", bus.i_rdata, exp_data);
      if (exp_dv) chk("d_rdata", bus.d_rdata, exp_data);
      if (v.eig || (v.edg && !v.dwe)) begin
         e.src    = v.edg;
         e.data   = mem_val(v.edg ? v.daddr : v.iaddr);
         e.due    = cyc + LAT;
         e.killed = 1'b0;
         q.push_back(e);
      end
      if (v.rst && v.ireq && v.dreq && exp_conf < 65535) exp_conf++;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   initial begin
      reset       = 1'b0;
      bus.i_req   = 1'b0;
      bus.i_addr  = '0;
      bus.i_kill  = 1'b0;
      bus.d_req   = 1'b0;
      bus.d_we    = 1'b0;
      bus.d_be    = '0;
      bus.d_addr  = '0;
      bus.d_wdata = '0;

      // Reset with both sides requesting: nothing granted, nothing counted.
      tbl.push_back(mk(1'b0, 1'b1, 32'h10, 1'b0, 1'b1, 1'b0, 4'hF, 32'h20, 32'h0, 1'b0, 1'b0));
      tbl.push_back(mk(1'b0, 1'b1, 32'h10, 1'b0, 1'b1, 1'b0, 4'hF, 32'h20, 32'h0, 1'b0, 1'b0));
      tbl.push_back(idle(1'b0));
      // Back-to-back fetches
      tbl.push_back(fetch(32'h0, 1'b0));
      tbl.push_back(fetch(32'h4, 1'b0));
      tbl.push_back(fetch(32'h8, 1'b0));
      for (int i = 0; i < 3; i++) tbl.push_back(idle(1'b0));
      // Contention: fetch forced through every STARVE_MAX+1 cycles
      for (int k = 0; k < 10; k++) begin
         tbl.push_back(mk(1'b1, 1'b1, 32'h40 + 32'(4*k), 1'b0, 1'b1, 1'b0, 4'hF,
                          32'h80 + 32'(4*k), 32'h0, (k % 5) == 4, (k % 5) != 4));
      end
      for (int i = 0; i < 3; i++) tbl.push_back(idle(1'b0));
      // Store then load
      tbl.push_back(mk(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 4'b0011, 32'h500, 32'hCAFE_F00D, 1'b0, 1'b1));
      tbl.push_back(load(32'h504));
      for (int i = 0; i < 3; i++) tbl.push_back(idle(1'b0));
      // Redirect with new fetch granted in the kill cycle
      tbl.push_back(fetch(32'h100, 1'b0));
      tbl.push_back(fetch(32'h104, 1'b1));
      for (int i = 0; i < 3; i++) tbl.push_back(idle(1'b0));
      // Kill does not touch an in-flight load
      tbl.push_back(load(32'h200));
      tbl.push_back(idle(1'b1));
      for (int i = 0; i < 2; i++) tbl.push_back(idle(1'b0));
      // Kill coincident with a fetch response at the tail
      tbl.push_back(fetch(32'h300, 1'b0));
      tbl.push_back(idle(1'b0));
      tbl.push_back(idle(1'b1));
      tbl.push_back(idle(1'b0));

      @(posedge clk);
      #1;
      for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

      // Reset mid-operation with a load and a fetch in flight
      step(mk(1'b1, 1'b1, 32'h604, 1'b0, 1'b1, 1'b0, 4'hF, 32'h600, 32'h0, 1'b0, 1'b1));
      step(fetch(32'h604, 1'b0));
      step(mk(1'b0, 1'b1, 32'h608, 1'b0, 1'b1, 1'b0, 4'hF, 32'h60C, 32'h0, 1'b0, 1'b0));
      step(mk(1'b0, 1'b1, 32'h608, 1'b0, 1'b1, 1'b0, 4'hF, 32'h60C, 32'h0, 1'b0, 1'b0));
      for (int i = 0; i < 4; i++) step(idle(1'b0));
      step(fetch(32'h700, 1'b0));
      for (int i = 0; i < 3; i++) step(idle(1'b0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
